// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
//   Shared types for the 2-read / 1-write register bank.
//   - state_e : bulk-clear sequencer state encoding (2 bits)
// ---------------------------------------------------------------------------
package regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage : regbank_pkg

// File: rtl/regbank_clr_fsm.sv
// ---------------------------------------------------------------------------
// regbank_clr_fsm
//   Bulk-clear sequencer for regbank_2r1w. Walks a pointer across every
//   register index, one per clock, and tells the array which entry to load
//   with the reset value. Also reports when the bank is idle so the array
//   can accept port writes.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | normal operation, port writes allowed, waiting for i_clr_req
//   ST_CLEAR | clearing reg[ptr] each cycle, ptr advances 0..NUM_REGS-1
//   ST_DONE  | one-cycle completion pulse, port writes still blocked
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   i_clr_req   in   single-cycle clear request (sampled only in ST_IDLE)
//   o_clr_busy  out  high for the NUM_REGS cycles of ST_CLEAR
//   o_clr_done  out  one-cycle pulse in ST_DONE
//   o_clr_we    out  clear-write strobe to the array
//   o_clr_addr  out  index being cleared this cycle
//   o_idle      out  high in ST_IDLE; gates port writes
// ---------------------------------------------------------------------------
module regbank_clr_fsm
    import regbank_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_idle
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_REGS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_clr_busy  = 1'b0;
        o_clr_done  = 1'b0;
        o_clr_we    = 1'b0;
        o_idle      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                o_idle = 1'b1;
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end

            ST_CLEAR: begin
                o_clr_busy = 1'b1;
                o_clr_we   = 1'b1;
                // Pointer holds at the last index on exit so it never wraps
                // inside one sequence; ST_IDLE reloads it on the next request.
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end
            end

            ST_DONE: begin
                o_clr_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_clr_addr = r_ptr;

endmodule : regbank_clr_fsm

// File: rtl/regbank_2r1w.sv
// ---------------------------------------------------------------------------
// regbank_2r1w
//   NUM_REGS x DATA_W register bank with one write port, two registered read
//   ports (rs/rt, 1-cycle latency) and a hardware bulk-clear sequencer.
//
//   Build option REGBANK_BYPASS_EN:
//     defined   - a write landing on the address being read in the same
//                 cycle is forwarded to the read port (port writes forward
//                 wr_data, clear writes forward RST_VAL).
//     undefined - same-cycle reads of the written address return the old
//                 value; no forwarding muxes exist.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   index width, NUM_REGS = 2**ADDR_W
//   RST_VAL  value loaded by reset and by the clear sequence
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   wr_en     in   write strobe (ignored while a clear is in progress)
//   wr_addr   in   write index
//   wr_data   in   write data
//   rs_addr   in   read port A index
//   rt_addr   in   read port B index
//   rs_data   out  read port A data, registered
//   rt_data   out  read port B data, registered
//   clr_req   in   single-cycle bulk-clear request
//   clr_busy  out  high while registers are being cleared
//   clr_done  out  one-cycle pulse when the clear completes
// ---------------------------------------------------------------------------
module regbank_2r1w
    import regbank_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    if (ADDR_W < 1 || DATA_W < 1) begin : g_param_err
        $error("regbank_2r1w: ADDR_W and DATA_W must both be >= 1");
    end

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_idle;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_port_we;
    logic [DATA_W-1:0] w_rs_nxt;
    logic [DATA_W-1:0] w_rt_nxt;

    regbank_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clr_req  (clr_req),
        .o_clr_busy (clr_busy),
        .o_clr_done (clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_idle     (w_idle)
    );

    // Port writes only land in IDLE; a write coinciding with clr_req is
    // therefore performed before the clear sequence starts.
    assign w_port_we = wr_en & w_idle;

    // w_port_we and w_clr_we are mutually exclusive (IDLE vs CLEAR).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else if (w_port_we) begin
            r_regs[wr_addr] <= wr_data;
        end else if (w_clr_we) begin
            r_regs[w_clr_addr] <= RST_VAL;
        end
    end

    always_comb begin
        w_rs_nxt = r_regs[rs_addr];
        w_rt_nxt = r_regs[rt_addr];
`ifdef REGBANK_BYPASS_EN
        if (w_port_we && (wr_addr == rs_addr)) begin
            w_rs_nxt = wr_data;
        end else if (w_clr_we && (w_clr_addr == rs_addr)) begin
            w_rs_nxt = RST_VAL;
        end
        if (w_port_we && (wr_addr == rt_addr)) begin
            w_rt_nxt = wr_data;
        end else if (w_clr_we && (w_clr_addr == rt_addr)) begin
            w_rt_nxt = RST_VAL;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs_data <= RST_VAL;
            rt_data <= RST_VAL;
        end else begin
            rs_data <= w_rs_nxt;
            rt_data <= w_rt_nxt;
        end
    end

endmodule : regbank_2r1w

// File: tb/tb_regbank_2r1w.sv
module tb_regbank_2r1w;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clock;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    int n_pass  = 0;
    int n_total = 0;

    regbank_2r1w #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RST_VAL (8'h00)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    logic [DATA_W-1:0] exp_collide;
    logic [DATA_W-1:0] exp_mid;
    int                busy_cnt;
    int                done_cnt;
    int                done_at;

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rs_addr = '0;
        rt_addr = '0;
        clr_req = 1'b0;

        // Reset state
        #23;
        check("rst_rs_data", rs_data, 8'h00);
        check("rst_rt_data", rt_data, 8'h00);
        check("rst_busy", clr_busy, 1'b0);
        check("rst_done", clr_done, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rs_addr = ADDR_W'(i);
            rt_addr = ADDR_W'(3 - i);
            tick();
            check($sformatf("rst_read_rs%0d", i), rs_data, 8'h00);
            check($sformatf("rst_read_rt%0d", 3 - i), rt_data, 8'h00);
        end
        check("idle_busy", clr_busy, 1'b0);
        check("idle_done", clr_done, 1'b0);

        // Write and dual read
        write_reg(2'd1, 8'hA5);
        write_reg(2'd2, 8'h3C);
        rs_addr = 2'd1;
        rt_addr = 2'd2;
        tick();
        check("dual_rs_r1", rs_data, 8'hA5);
        check("dual_rt_r2", rt_data, 8'h3C);
        rt_addr = 2'd1;
        tick();
        check("same_rs_r1", rs_data, 8'hA5);
        check("same_rt_r1", rt_data, 8'hA5);

        // Write/read collision
        write_reg(2'd3, 8'h11);
        rs_addr = 2'd3;
        rt_addr = 2'd2;
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 8'h22;
`ifdef REGBANK_BYPASS_EN
        exp_collide = 8'h22;
`else
        exp_collide = 8'h11;
`endif
        tick();
        wr_en = 1'b0;
        check("collide_rs", rs_data, exp_collide);
        check("collide_rt_other", rt_data, 8'h3C);
        tick();
        check("after_collide_rs", rs_data, 8'h22);

        // Clear sequence
        write_reg(2'd0, 8'h01);
        write_reg(2'd1, 8'h02);
        write_reg(2'd2, 8'h03);
        write_reg(2'd3, 8'h04);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("clr_busy_c%0d", c), clr_busy, 1'b1);
            check($sformatf("clr_done_c%0d", c), clr_done, 1'b0);
            if (c == 1) begin
                wr_en   = 1'b1;
                wr_addr = 2'd0;
                wr_data = 8'hFF;
                rs_addr = 2'd2;
                rt_addr = 2'd0;
            end
            tick();
            wr_en = 1'b0;
            if (c == 1) begin
                check("partial_rs_r2", rs_data, 8'h03);
                check("partial_rt_r0", rt_data, 8'h00);
            end
        end
        check("clr_end_busy", clr_busy, 1'b0);
        check("clr_end_done", clr_done, 1'b1);
        tick();
        check("clr_done_one_cycle", clr_done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rs_addr = ADDR_W'(i);
            rt_addr = ADDR_W'(i);
            tick();
            check($sformatf("cleared_rs%0d", i), rs_data, 8'h00);
            check($sformatf("cleared_rt%0d", i), rt_data, 8'h00);
        end

        // Clear with concurrent write
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 8'h77;
        rs_addr = 2'd2;
        tick();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        check("cw_busy", clr_busy, 1'b1);
        tick();
        check("cw_write_landed", rs_data, 8'h77);
        tick();
        tick();
        tick();
        check("cw_done", clr_done, 1'b1);
        tick();
        check("cw_r2_cleared", rs_data, 8'h00);

        // Reset in the middle of a clear
        write_reg(2'd1, 8'h5A);
        write_reg(2'd3, 8'hC3);
        rs_addr = 2'd1;
        rt_addr = 2'd3;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        check("mid_rs_r1_before", rs_data, 8'h5A);
`ifdef REGBANK_BYPASS_EN
        exp_mid = 8'h00;
`else
        exp_mid = 8'h5A;
`endif
        tick();
        check("mid_rs_r1_clearing", rs_data, exp_mid);
        check("mid_rt_r3", rt_data, 8'hC3);
        check("mid_busy", clr_busy, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_rt", rt_data, 8'h00);
        check("arst_rs", rs_data, 8'h00);
        check("arst_busy", clr_busy, 1'b0);
        check("arst_done", clr_done, 1'b0);
        #12;
        @(negedge clock);
        reset_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clr_done) done_cnt++;
            if (clr_busy) busy_cnt++;
        end
        check("arst_no_done", done_cnt, 0);
        check("arst_no_busy", busy_cnt, 0);
        check("arst_r3_value", rt_data, 8'h00);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 10; i++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done && done_at < 0) done_at = i;
            tick();
        end
        check("reclr_busy_cycles", busy_cnt, 4);
        check("reclr_done_cycle", done_at, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regbank_2r1w

// File: doc/regbank_2r1w.md
Name: regbank_2r1w

Overview:
- Parametrised successor to the single-port 4x8 register bank: N x W array, one write port, two independent synchronous read ports (rs/rt), plus a hardware bulk-clear sequencer.
- Sits between instruction decode (addresses) and the ALU/writeback path of the processor datapath.
- All activity is on the rising edge of clock.
- The negedge read of the previous generation is replaced by a registered posedge read with defined write/read collision behaviour.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 2, address width; NUM_REGS = 2**ADDR_W, a derived localparam that is not overridable.
- RST_VAL, 0, DATA_W-bit value loaded by reset and by the clear sequence.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- rs_addr  in  ADDR_W  read port A index.
- rt_addr  in  ADDR_W  read port B index.
- rs_data  out  DATA_W  read port A data, registered.
- rt_data  out  DATA_W  read port B data, registered.
- clr_req  in  1  single-cycle request to clear all registers.
- clr_busy  out  1  high while the clear sequence is running.
- clr_done  out  1  one-cycle pulse when the clear sequence finishes.

Behaviour:
- Reset: asserting reset_n=0 takes effect immediately and asynchronously. Every register, rs_data and rt_data take RST_VAL; clr_busy=0, clr_done=0; FSM goes to IDLE; clear pointer goes to 0.
- Write: when wr_en=1 and the FSM is IDLE, reg[wr_addr] <= wr_data at the rising edge. wr_en is silently dropped in CLEAR and DONE; there is no backpressure.
- Read: every edge, rs_data <= reg[rs_addr] and rt_data <= reg[rt_addr]. Latency is 1 cycle. Both ports may use the same address. Outputs update unconditionally; there is no read enable.
- Collision without bypass: a read of the address being written in the same cycle returns the OLD value. The new value is visible from the next read onward.
- FSM IDLE:
  - clr_req=1 -> CLEAR with ptr=0.
  - If clr_req and wr_en are both high in the same IDLE cycle, the write is performed first, then CLEAR begins.
- FSM CLEAR:
  - clr_busy=1.
  - Each cycle: reg[ptr] <= RST_VAL, ptr <= ptr+1.
  - When ptr==NUM_REGS-1 -> DONE. CLEAR therefore lasts exactly NUM_REGS cycles.
  - clr_req is ignored.
- FSM DONE: clr_busy=0, clr_done=1 for one cycle -> IDLE. wr_en is still dropped in DONE.
- Total clear turnaround: clr_req sampled at edge k -> clr_done high in cycle k+NUM_REGS+1.
- Reads during CLEAR return the current array contents, i.e. partially cleared.
- Reset mid-clear: sequence aborted; all registers take RST_VAL; FSM to IDLE; no clr_done pulse.
- Pointer width is ADDR_W. It does not wrap past NUM_REGS-1 within one sequence.
- Parameter-set check: ADDR_W>=1 and DATA_W>=1 hold for every parameter set the block is instantiated with.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: write-to-read forwarding. If an effective write targets the address being read in the same cycle, the read port returns the new value. An effective write is a port write in IDLE, or a clear write in CLEAR, which forwards RST_VAL. Read latency is unchanged at 1 cycle.
- Undefined: old-value collision semantics as above. No forwarding muxes are synthesised.

Decomposition:
- Package regbank_pkg: FSM state enum (ST_IDLE, ST_CLEAR, ST_DONE, 2-bit encoding).
- Sub-module regbank_clr_fsm: holds state, ptr, clr_busy, clr_done. It outputs clr_we/clr_addr to the array, plus an idle flag that gates wr_en.
- The array and read registers stay in regbank_2r1w.

Test Plan (DATA_W=8, ADDR_W=2, RST_VAL=0):
- Reset then read: reset_n low, release; rs_addr=0..3, rt_addr=3..0 -> all reads 0x00; clr_busy=0, clr_done=0.
- Write/dual read: write 0xA5->r1 and 0x3C->r2 on consecutive cycles; then rs_addr=1, rt_addr=2 -> next cycle rs_data=0xA5, rt_data=0x3C. Also rs_addr=rt_addr=1 -> both ports 0xA5.
- Collision: r3=0x11; then in the same cycle wr 0x22->r3 and rs_addr=3 -> rs_data=0x11 without the macro, 0x22 with it. The next read returns 0x22 in both builds.
- Clear sequence: load r0..r3 = 1,2,3,4; pulse clr_req -> clr_busy high for exactly 4 cycles, then clr_done pulses once. A wr_en 0xFF->r0 issued during busy is dropped. Afterwards all registers read 0x00.
- Clear with concurrent write: the IDLE cycle with clr_req=1 and wr 0x77->r2 -> write performed, then cleared; r2 reads 0x00 after clr_done.
- Reset mid-clear: assert reset_n two cycles into CLEAR, at an arbitrary clock phase -> outputs 0 immediately; no clr_done; a subsequent clr_req completes a normal 4-cycle sequence.
